ad95xx_spi_master: RTL and testbench



---
 rtl/ad95xx_spi_master.sv | 167 ++++++++++++++++
 tb/tb_ad95xx_spi_master.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad95xx_spi_master.sv
// 3-wire SPI master for AD95xx parts: MSB-first writes, optional readback over shared SDIO.
// Frame: SETUP (H) -> DW SCLK periods (2H each) -> GAP (2H, csb high) -> IDLE.
module ad95xx_spi_master #(
  parameter int DW       = 24,
  parameter int HDR_W    = 16,
  parameter int HALF_PER = 2,
  parameter int READ_EN  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DW-1:0]       send_data,
  input  logic                write_strobe,
  output logic                busy,
  output logic                done,
  output logic [DW-HDR_W-1:0] read_data,
  output logic                chip_sclk,
  output logic                chip_csb,
  output logic                chip_sdio_out,
  output logic                chip_sdio_oe,
  input  logic                chip_sdio_in
);

  localparam int RW = DW - HDR_W;
  localparam int CW = (2 * HALF_PER > 1) ? $clog2(2 * HALF_PER) : 1;
  localparam int EW = $clog2(DW + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_PER - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(2 * HALF_PER - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(DW);
  localparam logic [EW-1:0] EDGE_HDR  = EW'(HDR_W);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  state_t          state_reg, state_next;
  logic [DW-1:0]   shift_reg, shift_next;
  logic [RW-1:0]   rx_reg, rx_next;
  logic [RW-1:0]   read_data_reg, read_data_next;
  logic            rd_reg, rd_next;
  logic [CW-1:0]   half_reg, half_next;
  logic [EW-1:0]   edge_reg, edge_next;
  logic            sclk_reg, sclk_next;
  logic            csb_reg, csb_next;
  logic            oe_reg, oe_next;
  logic            sdo_reg, sdo_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      rx_reg        <= '0;
      read_data_reg <= '0;
      rd_reg        <= 1'b0;
      half_reg      <= '0;
      edge_reg      <= '0;
      sclk_reg      <= 1'b0;
      csb_reg       <= 1'b1;
      oe_reg        <= 1'b0;
      sdo_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      rx_reg        <= rx_next;
      read_data_reg <= read_data_next;
      rd_reg        <= rd_next;
      half_reg      <= half_next;
      edge_reg      <= edge_next;
      sclk_reg      <= sclk_next;
      csb_reg       <= csb_next;
      oe_reg        <= oe_next;
      sdo_reg       <= sdo_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    rx_next        = rx_reg;
    read_data_next = read_data_reg;
    rd_next        = rd_reg;
    half_next      = half_reg;
    edge_next      = edge_reg;
    sclk_next      = sclk_reg;
    csb_next       = csb_reg;
    oe_next        = oe_reg;
    sdo_next       = sdo_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (write_strobe) begin
          shift_next = send_data;
          rd_next    = (READ_EN != 0) && send_data[DW-1];
          rx_next    = '0;
          half_next  = '0;
          edge_next  = '0;
          busy_next  = 1'b1;
          csb_next   = 1'b0;
          oe_next    = 1'b1;
          sdo_next   = send_data[DW-1];
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (half_reg == HALF_LAST) begin
          half_next  = '0;
          sclk_next  = 1'b1;
          edge_next  = edge_reg + EW'(1);
          state_next = SHIFT;
        end else begin
          half_next = half_reg + CW'(1);
        end
      end
      SHIFT: begin
        if (half_reg != HALF_LAST) begin
          half_next = half_reg + CW'(1);
        end else begin
          half_next = '0;
          if (sclk_reg) begin
            // Falling SCLK: present next bit, release SDIO after the header, capture read bits.
            sclk_next  = 1'b0;
            shift_next = shift_reg << 1;
            sdo_next   = shift_reg[DW-2];
            if (rd_reg && edge_reg == EDGE_HDR)
              oe_next = 1'b0;
            if (rd_reg && edge_reg > EDGE_HDR)
              rx_next = (rx_reg << 1) | RW'(chip_sdio_in);
          end else if (edge_reg == EDGE_LAST) begin
            csb_next   = 1'b1;
            oe_next    = 1'b0;
            sdo_next   = 1'b0;
            done_next  = 1'b1;
            if (rd_reg)
              read_data_next = rx_reg;
            state_next = GAP;
          end else begin
            sclk_next = 1'b1;
            edge_next = edge_reg + EW'(1);
          end
        end
      end
      GAP: begin
        if (half_reg == GAP_LAST) begin
          half_next  = '0;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          half_next = half_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign read_data     = read_data_reg;
  assign chip_sclk     = sclk_reg;
  assign chip_csb      = csb_reg;
  assign chip_sdio_out = sdo_reg;
  assign chip_sdio_oe  = oe_reg;

endmodule

// File: tb/tb_ad95xx_spi_master.sv
// Directed bench: default 24-bit readback instance plus a 16-bit write-only instance (H=1).
module tb_ad95xx_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [23:0] wd0 = '0;
  logic        ws0 = 1'b0;
  logic        busy0, done0, sclk0, csb0, sdo0, oe0;
  logic [7:0]  rd0;
  logic        sdi0 = 1'b0;

  logic [15:0] wd1 = '0;
  logic        ws1 = 1'b0;
  logic        busy1, done1, sclk1, csb1, sdo1, oe1;
  logic [7:0]  rd1;
  logic        sdi1 = 1'b1;

  ad95xx_spi_master #(.DW(24), .HDR_W(16), .HALF_PER(2), .READ_EN(1)) dut0 (
    .clk(clk), .rst(rst), .send_data(wd0), .write_strobe(ws0), .busy(busy0), .done(done0),
    .read_data(rd0), .chip_sclk(sclk0), .chip_csb(csb0), .chip_sdio_out(sdo0),
    .chip_sdio_oe(oe0), .chip_sdio_in(sdi0)
  );

  ad95xx_spi_master #(.DW(16), .HDR_W(8), .HALF_PER(1), .READ_EN(0)) dut1 (
    .clk(clk), .rst(rst), .send_data(wd1), .write_strobe(ws1), .busy(busy1), .done(done1),
    .read_data(rd1), .chip_sclk(sclk1), .chip_csb(csb1), .chip_sdio_out(sdo1),
    .chip_sdio_oe(oe1), .chip_sdio_in(sdi1)
  );

  // Chip model: after the 16th falling SCLK edge, drive 0xA5 MSB first on each falling edge.
  int         chip_falls = 0;
  logic [7:0] chip_pat = 8'hA5;
  always @(negedge sclk0 or posedge csb0) begin
    if (csb0) begin
      chip_falls = 0;
      sdi0 = 1'b0;
    end else begin
      chip_falls++;
      if (chip_falls >= 16 && chip_falls <= 23) sdi0 = chip_pat[23 - chip_falls];
      else sdi0 = 1'b0;
    end
  end

  // Pin monitor for both instances, sampled on the falling clk edge.
  logic [1:0] m_sclk, m_csb, m_oe, m_sdo, m_busy, m_done;
  assign m_sclk = {sclk1, sclk0};
  assign m_csb  = {csb1, csb0};
  assign m_oe   = {oe1, oe0};
  assign m_sdo  = {sdo1, sdo0};
  assign m_busy = {busy1, busy0};
  assign m_done = {done1, done0};

  logic        prev_sclk [2] = '{1'b0, 1'b0};
  logic        prev_csb  [2] = '{1'b1, 1'b1};
  logic        prev_busy [2] = '{1'b0, 1'b0};
  int          rise_cnt [2] = '{0, 0};
  int          drv_bits [2] = '{0, 0};
  logic [63:0] drv_word [2] = '{64'd0, 64'd0};
  int          oe_fall  [2] = '{0, 0};
  int          low_cnt  [2] = '{0, 0};
  int          high_run [2] = '{0, 0};
  int          last_high[2] = '{0, 0};
  int          frame_cnt[2] = '{0, 0};
  int          busy_cnt [2] = '{0, 0};
  int          done_cnt [2] = '{0, 0};
  int          fin_rise [2] = '{0, 0};
  int          fin_bits [2] = '{0, 0};
  logic [63:0] fin_word [2] = '{64'd0, 64'd0};
  int          fin_oe   [2] = '{0, 0};
  int          fin_low  [2] = '{0, 0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_csb[k] && !prev_csb[k]) begin
        fin_rise[k] = rise_cnt[k];
        fin_bits[k] = drv_bits[k];
        fin_word[k] = drv_word[k];
        fin_oe[k]   = oe_fall[k];
        fin_low[k]  = low_cnt[k];
      end
      if (!m_csb[k] && prev_csb[k]) begin
        frame_cnt[k]++;
        rise_cnt[k]  = 0;
        drv_bits[k]  = 0;
        drv_word[k]  = 64'd0;
        oe_fall[k]   = 0;
        low_cnt[k]   = 0;
        last_high[k] = high_run[k];
        high_run[k]  = 0;
      end
      if (!m_csb[k]) begin
        low_cnt[k]++;
        if (m_sclk[k] && !prev_sclk[k]) begin
          rise_cnt[k]++;
          if (m_oe[k]) begin
            drv_word[k] = {drv_word[k][62:0], m_sdo[k]};
            drv_bits[k]++;
          end
        end
        if (!m_oe[k] && oe_fall[k] == 0) oe_fall[k] = rise_cnt[k];
      end else begin
        high_run[k]++;
      end
      if (m_busy[k] && !prev_busy[k]) begin
        busy_cnt[k] = 0;
        done_cnt[k] = 0;
      end
      if (m_busy[k]) busy_cnt[k]++;
      if (m_done[k]) done_cnt[k]++;
      prev_sclk[k] = m_sclk[k];
      prev_csb[k]  = m_csb[k];
      prev_busy[k] = m_busy[k];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start0(input logic [23:0] w);
    @(posedge clk); #1;
    wd0 = w;
    ws0 = 1'b1;
    @(posedge clk); #1;
    ws0 = 1'b0;
  endtask

  task automatic start1(input logic [15:0] w);
    @(posedge clk); #1;
    wd1 = w;
    ws1 = 1'b1;
    @(posedge clk); #1;
    ws1 = 1'b0;
  endtask

  task automatic wait_idle0(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (!busy0) break;
      @(negedge clk);
    end
    chk(tag, 64'(busy0), 64'd0);
  endtask

  task automatic wait_idle1(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (!busy1) break;
      @(negedge clk);
    end
    chk(tag, 64'(busy1), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int fc;
    // Reset, including a strobe coincident with reset
    repeat (2) @(posedge clk);
    #1 ws0 = 1'b1;
    @(negedge clk);
    chk("reset_pins0", 64'({csb0, sclk0, sdo0, oe0, busy0, done0}), 64'b100000);
    chk("reset_rdata0", 64'(rd0), 64'h00);
    chk("reset_pins1", 64'({csb1, sclk1, sdo1, oe1, busy1, done1}), 64'b100000);
    @(posedge clk); #1;
    rst = 1'b0;
    ws0 = 1'b0;
    @(negedge clk);
    chk("rst_beats_strobe", 64'({csb0, busy0}), 64'b10);

    // Reset in the middle of a read frame
    start0(24'h812345);
    for (int i = 0; i < 400; i++) begin
      if (rise_cnt[0] >= 10) break;
      @(negedge clk);
    end
    chk("midrst_reached_10", 64'(rise_cnt[0] >= 10), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_pins", 64'({csb0, sclk0, oe0, busy0, done0}), 64'b10000);
    chk("midrst_rdata", 64'(rd0), 64'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_rises", 64'(fin_rise[0]), 64'd10);
    chk("midrst_no_done", 64'(done_cnt[0]), 64'd0);

    // Write after the aborted read
    start0(24'h00ABCD);
    wait_idle0("abcd_idle");
    chk("abcd_word", fin_word[0], 64'h00ABCD);
    chk("abcd_rises", 64'(fin_rise[0]), 64'd24);
    chk("abcd_done", 64'(done_cnt[0]), 64'd1);
    chk("abcd_rdata", 64'(rd0), 64'h00);

    // Plain write
    start0(24'h123456);
    wait_idle0("w123456_idle");
    chk("w123456_word", fin_word[0], 64'h123456);
    chk("w123456_bits", 64'(fin_bits[0]), 64'd24);
    chk("w123456_rises", 64'(fin_rise[0]), 64'd24);
    chk("w123456_csb_low", 64'(fin_low[0]), 64'd98);
    chk("w123456_oe_fall", 64'(fin_oe[0]), 64'd0);
    chk("w123456_busy", 64'(busy_cnt[0]), 64'd102);
    chk("w123456_done", 64'(done_cnt[0]), 64'd1);

    // Readback
    start0(24'h800300);
    for (int i = 0; i < 400; i++) begin
      if (done0) break;
      @(negedge clk);
    end
    chk("read_done_seen", 64'(done0), 64'd1);
    chk("read_rdata_at_done", 64'(rd0), 64'hA5);
    wait_idle0("read_idle");
    chk("read_hdr_word", fin_word[0], 64'h8003);
    chk("read_hdr_bits", 64'(fin_bits[0]), 64'd16);
    chk("read_oe_fall", 64'(fin_oe[0]), 64'd16);
    chk("read_rises", 64'(fin_rise[0]), 64'd24);
    chk("read_busy", 64'(busy_cnt[0]), 64'd102);
    chk("read_done", 64'(done_cnt[0]), 64'd1);

    // Strobes while busy are ignored
    fc = frame_cnt[0];
    start0(24'h5A5A5A);
    wd0 = 24'hFFFFFF;
    repeat (1) @(posedge clk);
    #1 ws0 = 1'b1;
    @(posedge clk); #1 ws0 = 1'b0;
    repeat (16) @(posedge clk);
    #1 ws0 = 1'b1;
    @(posedge clk); #1 ws0 = 1'b0;
    repeat (39) @(posedge clk);
    #1 ws0 = 1'b1;
    @(posedge clk); #1 ws0 = 1'b0;
    wait_idle0("ignore_idle");
    repeat (10) @(negedge clk);
    chk("ignore_frames", 64'(frame_cnt[0] - fc), 64'd1);
    chk("ignore_word", fin_word[0], 64'h5A5A5A);
    chk("ignore_rises", 64'(fin_rise[0]), 64'd24);
    chk("ignore_csb_idle", 64'(csb0), 64'd1);
    chk("ignore_rdata_kept", 64'(rd0), 64'hA5);

    // Back-to-back frames
    start0(24'h3C3C3C);
    wait_idle0("b2b_first_idle");
    wd0 = 24'h0F1E2D;
    ws0 = 1'b1;
    chk("b2b_first_word", fin_word[0], 64'h3C3C3C);
    @(posedge clk); #1 ws0 = 1'b0;
    wait_idle0("b2b_second_idle");
    chk("b2b_second_word", fin_word[0], 64'h0F1E2D);
    chk("b2b_csb_high", 64'(last_high[0]), 64'd5);
    chk("b2b_csb_low", 64'(fin_low[0]), 64'd98);
    chk("b2b_rdata_kept", 64'(rd0), 64'hA5);

    // 16-bit, H=1, write-only instance with MSB set
    start1(16'h9234);
    wait_idle1("d16_idle");
    chk("d16_word", fin_word[1], 64'h9234);
    chk("d16_bits", 64'(fin_bits[1]), 64'd16);
    chk("d16_rises", 64'(fin_rise[1]), 64'd16);
    chk("d16_csb_low", 64'(fin_low[1]), 64'd33);
    chk("d16_oe_fall", 64'(fin_oe[1]), 64'd0);
    chk("d16_busy", 64'(busy_cnt[1]), 64'd35);
    chk("d16_done", 64'(done_cnt[1]), 64'd1);
    chk("d16_rdata", 64'(rd1), 64'h00);
    start1(16'h1FE0);
    wait_idle1("d16b_idle");
    chk("d16b_word", fin_word[1], 64'h1FE0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
